// File: rtl/dll_tap_ctrl.sv
// FMDLL delay-line loop controller: turns phase-detector up/dn decisions into a
// tap code, with a raw-vote coarse SEARCH, a filtered TRACK phase and lock detect.
module dll_tap_ctrl #(
  parameter int CODE_W    = 4,
  parameter int MIN_CODE  = 1,
  parameter int MAX_CODE  = 15,
  parameter int INIT_CODE = 8,
  parameter int SETTLE    = 4,
  parameter int FILT_THR  = 8,
  parameter int LOCK_WIN  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] Q,
  output logic              locked,
  output logic              sat
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int QW = $clog2(LOCK_WIN + 1);
  localparam int AW = $clog2(FILT_THR + 1) + 1;

  localparam logic [CODE_W-1:0] CODE_MIN  = CODE_W'(MIN_CODE);
  localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(MAX_CODE);
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
  localparam logic [SW-1:0]     SETTLE_LD = SW'(SETTLE);
  localparam logic [QW-1:0]     QUIET_MAX = QW'(LOCK_WIN);
  localparam logic signed [AW-1:0] THR_POS = AW'(FILT_THR);
  localparam logic signed [AW-1:0] THR_NEG = -THR_POS;

  typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_t;

  state_t                 state, state_nxt;
  logic [CODE_W-1:0]      q_nxt;
  logic                   locked_nxt, sat_nxt;
  logic signed [AW-1:0]   acc, acc_nxt, acc_sum, vote;
  logic [SW-1:0]          settle_cnt, settle_nxt;
  logic [QW-1:0]          quiet, quiet_nxt;
  logic [1:0]             rev, rev_nxt;
  logic                   dir_vld, dir_vld_nxt;
  logic                   dir_up, dir_up_nxt;
  logic                   vote_up, vote_dn, live, step_up, blocked;

  assign vote_up = pd_up & ~pd_dn;
  assign vote_dn = pd_dn & ~pd_up;
  assign vote    = vote_up ? AW'(1) : (vote_dn ? -AW'(1) : AW'(0));
  assign live    = (settle_cnt == '0);
  assign acc_sum = acc + vote;

  // NOTE: every next-state variable gets a default before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    q_nxt       = Q;
    locked_nxt  = locked;
    sat_nxt     = 1'b0;
    acc_nxt     = acc;
    settle_nxt  = live ? settle_cnt : settle_cnt - SW'(1);
    quiet_nxt   = quiet;
    rev_nxt     = rev;
    dir_vld_nxt = dir_vld;
    dir_up_nxt  = dir_up;
    step_up     = 1'b0;
    blocked     = 1'b0;

    if (!en) begin
      state_nxt   = IDLE;
      q_nxt       = '0;
      locked_nxt  = 1'b0;
      acc_nxt     = '0;
      settle_nxt  = '0;
      quiet_nxt   = '0;
      rev_nxt     = '0;
      dir_vld_nxt = 1'b0;
      dir_up_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = SEARCH;
          q_nxt       = CODE_INIT;
          settle_nxt  = SETTLE_LD;
          rev_nxt     = '0;
          dir_vld_nxt = 1'b0;
        end

        SEARCH: begin
          if (live && (vote_up || vote_dn)) begin
            step_up    = vote_up;
            blocked    = step_up ? (Q == CODE_MAX) : (Q == CODE_MIN);
            settle_nxt = SETTLE_LD;
            if (blocked) begin
              sat_nxt = 1'b1;
            end else begin
              q_nxt       = step_up ? Q + CODE_W'(1) : Q - CODE_W'(1);
              dir_vld_nxt = 1'b1;
              dir_up_nxt  = step_up;
              if (dir_vld && (dir_up != step_up)) begin
                rev_nxt = rev + 2'd1;
                // Second reversal: loop has bracketed the target, hand over to TRACK.
                if (rev == 2'd1) begin
                  state_nxt   = TRACK;
                  acc_nxt     = '0;
                  quiet_nxt   = '0;
                  dir_vld_nxt = 1'b0;
                end
              end
            end
          end
        end

        TRACK: begin
          if (quiet != QUIET_MAX) quiet_nxt = quiet + QW'(1);
          if (quiet == QUIET_MAX) locked_nxt = 1'b1;
          if (live) begin
            if (acc_sum == THR_POS || acc_sum == THR_NEG) begin
              step_up    = (acc_sum == THR_POS);
              blocked    = step_up ? (Q == CODE_MAX) : (Q == CODE_MIN);
              acc_nxt    = '0;
              settle_nxt = SETTLE_LD;
              quiet_nxt  = '0;
              if (blocked) begin
                sat_nxt = 1'b1;
              end else begin
                q_nxt = step_up ? Q + CODE_W'(1) : Q - CODE_W'(1);
                // Repeated same-direction corrections mean the loop is drifting.
                if (dir_vld && (dir_up == step_up)) locked_nxt = 1'b0;
                dir_vld_nxt = 1'b1;
                dir_up_nxt  = step_up;
              end
            end else begin
              acc_nxt = acc_sum;
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous (sampled only on the clock edge), and all state
  // uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      Q          <= '0;
      locked     <= 1'b0;
      sat        <= 1'b0;
      acc        <= '0;
      settle_cnt <= '0;
      quiet      <= '0;
      rev        <= '0;
      dir_vld    <= 1'b0;
      dir_up     <= 1'b0;
    end else begin
      state      <= state_nxt;
      Q          <= q_nxt;
      locked     <= locked_nxt;
      sat        <= sat_nxt;
      acc        <= acc_nxt;
      settle_cnt <= settle_nxt;
      quiet      <= quiet_nxt;
      rev        <= rev_nxt;
      dir_vld    <= dir_vld_nxt;
      dir_up     <= dir_up_nxt;
    end
  end

endmodule

// File: tb/tb_dll_tap_ctrl.sv
// Self-checking bench for dll_tap_ctrl: expected outputs are queued with each
// cycle's stimulus and compared after the following rising edge.
module tb_dll_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, pd_up, pd_dn;
  logic [3:0] q;
  logic       locked, sat;

  always #5 clk = ~clk;

  dll_tap_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .pd_up  (pd_up),
    .pd_dn  (pd_dn),
    .Q      (q),
    .locked (locked),
    .sat    (sat)
  );

  typedef enum {F_Q, F_LOCK, F_SAT} field_t;
  typedef struct {
    string  tag;
    field_t fld;
    int     val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input field_t fld, input int val);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input string tag, input int qv, input int lk, input int st);
    push({tag, "_q"}, F_Q, qv);
    push({tag, "_locked"}, F_LOCK, lk);
    push({tag, "_sat"}, F_SAT, st);
  endtask

  // Advance one edge, then retire everything queued for it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.fld)
        F_Q:    check(e.tag, 32'(q), e.val);
        F_LOCK: check(e.tag, 32'(locked), e.val);
        default: check(e.tag, 32'(sat), e.val);
      endcase
    end
  endtask

  task automatic drive(input logic up, input logic dn);
    pd_up = up;
    pd_dn = dn;
  endtask

  initial begin
    int exq;

    // Reset dominates en and pd votes.
    rst_n = 1'b0; en = 1'b1; drive(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      push_all("reset", 0, 0, 0);
      tick();
    end

    // Enable: INIT_CODE one cycle later, then paced climb into MAX and sat pulses.
    rst_n = 1'b1;
    push_all("en_rise", 8, 0, 0);
    tick();
    for (int c = 2; c <= 51; c++) begin
      exq = 8 + (c - 1) / 5;
      if (exq > 15) exq = 15;
      push_all("search_up", exq, 0, (c >= 41 && (c - 1) % 5 == 0) ? 1 : 0);
      tick();
    end

    en = 1'b0;
    push_all("disable_a", 0, 0, 0);
    tick();

    // Descent into MIN_CODE; Q must never reach 0 while active.
    en = 1'b1; drive(1'b0, 1'b1);
    push_all("en_rise_dn", 8, 0, 0);
    tick();
    for (int c = 2; c <= 46; c++) begin
      exq = 8 - (c - 1) / 5;
      if (exq < 1) exq = 1;
      push_all("search_dn", exq, 0, (c >= 41 && (c - 1) % 5 == 0) ? 1 : 0);
      tick();
    end

    en = 1'b0;
    push_all("disable_b", 0, 0, 0);
    tick();

    // Convergence around 11: 8,9,10,11,10,11 then TRACK.
    en = 1'b1; drive(1'b1, 1'b0);
    push("conv_init", F_Q, 8);
    tick();
    exq = 8;
    for (int c = 2; c <= 26; c++) begin
      drive(exq < 11, exq >= 11);
      if ((c - 1) % 5 == 0) exq = (exq < 11) ? exq + 1 : exq - 1;
      push("conv", F_Q, exq);
      tick();
    end

    // TRACK: raw votes no longer step; 7 votes hold, the 8th steps.
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      push("track_settle", F_Q, 11);
      tick();
    end
    drive(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      push("track_filter", F_Q, 11);
      tick();
    end
    drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push("track_hold", F_Q, 11);
      tick();
    end
    drive(1'b1, 1'b0);
    push_all("track_step", 12, 0, 0);
    tick();

    // Quiet window: 64 + SETTLE vote-free cycles ends with locked.
    drive(1'b0, 1'b0);
    for (int i = 0; i < 68; i++) begin
      push("lock_wait", F_Q, 12);
      if (i == 0)  push("lock_early", F_LOCK, 0);
      if (i == 67) push("lock_set", F_LOCK, 1);
      tick();
    end

    // Conflicting votes are null: no step, lock holds.
    drive(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      push("conflict_q", F_Q, 12);
      push("conflict_lock", F_LOCK, 1);
      tick();
    end

    // Drift: 16 counted up votes give two +1 steps and drop lock.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      push("drift_a", F_Q, (i == 7) ? 13 : 12);
      tick();
    end
    drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push("drift_gap", F_Q, 13);
      tick();
    end
    drive(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      push("drift_b", F_Q, (i == 7) ? 14 : 13);
      if (i == 7) push("drift_unlock", F_LOCK, 0);
      tick();
    end

    // Disable mid-accumulation, then a fresh SEARCH on re-enable.
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      push("pre_dis", F_Q, 14);
      tick();
    end
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push("acc_part", F_Q, 14);
      tick();
    end
    en = 1'b0; drive(1'b0, 1'b0);
    push_all("disable_mid", 0, 0, 0);
    tick();
    en = 1'b1; drive(1'b1, 1'b0);
    push_all("reenable", 8, 0, 0);
    tick();
    for (int c = 2; c <= 11; c++) begin
      push("fresh_search", F_Q, 8 + (c - 1) / 5);
      push("fresh_lock", F_LOCK, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
